nibble_add_seq: RTL and testbench
=================================

# nibble_add_seq

Sequential operand feeder and result collector for the team's 4-bit ripple-carry adder stage. It accepts a wide add request over a valid/ready handshake and presents the operands to the external combinational 4-bit adder one nibble per cycle, least significant nibble first. The adder's carry-out is chained back into its carry-in on the next cycle. The block assembles the sum nibbles into a wide result and returns it over a second valid/ready handshake. It sits directly upstream and downstream of the 4-bit adder and is its only driver.

## Interface
- `NIBBLES`, default 4: number of 4-bit slices. Operand width W = 4*NIBBLES. Legal range is 1 to 16.
- `clk` input, 1: sole clock; all state updates on the rising edge.
- `rst_n` input, 1: reset, asynchronous, active-low.
- `in_valid` input, 1: request valid.
- `in_ready` output, 1: block can accept a request.
- `in_a` input, W: operand A.
- `in_b` input, W: operand B.
- `in_cin` input, 1: initial carry-in.
- `in_sub` input, 1: subtract request (see Configuration).
- `add_a` output, 4: nibble of A to the adder.
- `add_b` output, 4: nibble of B to the adder.
- `add_cin` output, 1: carry to the adder.
- `add_sum` input, 4: adder sum, combinational from `add_a`/`add_b`/`add_cin`.
- `add_cout` input, 1: adder carry-out.
- `out_valid` output, 1: result valid.
- `out_ready` input, 1: consumer accepts the result.
- `out_sum` output, W: assembled sum.
- `out_cout` output, 1: final carry-out.

## Operation
- The state machine has three states: IDLE, RUN and DONE. Reset forces IDLE.
- `in_ready` = (state == IDLE). It therefore reads 1 while `rst_n` is low.
- IDLE → RUN on `in_valid & in_ready`. On that edge the block:
  - registers `in_a` and `in_b`;
  - loads the carry register with `in_cin`;
  - clears nibble index `idx` to 0.
- In RUN:
  - `add_a` = A[4*idx+3:4*idx].
  - `add_b` = B[4*idx+3:4*idx].
  - `add_cin` = carry register.
- On each RUN edge:
  - result nibble `idx` <= `add_sum`;
  - carry register <= `add_cout`;
  - `idx` <= `idx`+1.
- RUN → DONE on the edge where `idx` == NIBBLES-1. That edge also loads `out_cout` from `add_cout`.
- In DONE, `out_valid` = 1 and `out_sum`/`out_cout` are stable.
- DONE → IDLE on `out_valid & out_ready`.
- Outside RUN, `add_a`, `add_b` and `add_cin` are driven to 0.
- `in_valid` is ignored in RUN and DONE. Operand inputs are sampled only on the accept edge.
- Arithmetic is modulo 2^W, with carry out of bit W-1 reported on `out_cout`.
- Reset values:
  - `out_valid` 0;
  - `out_sum` 0;
  - `out_cout` 0;
  - `add_a`/`add_b`/`add_cin` 0;
  - `idx` 0;
  - carry register 0.
- Reset asserted mid-RUN or in DONE aborts the operation immediately. The partial result is discarded (cleared to 0), and no `out_valid` pulse follows.

## Timing
- Accept at edge k. RUN occupies the cycles after edges k through k+NIBBLES-1.
- `out_valid` rises after edge k+NIBBLES. Latency is NIBBLES+1 cycles from the accept edge to the first cycle of `out_valid`.
- `out_valid` holds until the edge where `out_ready` is sampled high. `in_ready` rises in the following cycle.
- With `out_ready` tied high, throughput is one request per NIBBLES+2 cycles.
- The nibble issued in cycle idx is combinational from registered state. The adder path must settle within one cycle.
- DONE and IDLE never overlap, so a result handoff and a new accept cannot occur on the same edge.

## Configuration
- Macro: `NIBBLE_ADD_SEQ_SUB_EN`.
- Defined:
  - `in_sub` = 1 at accept registers ~`in_b` as B and forces the initial carry to 1, ignoring `in_cin`. The result is A − B.
  - `out_cout` = 1 means no borrow.
  - `in_sub` = 0 behaves as a normal add.
- Undefined: `in_sub` is ignored (port present, unused), and every request is A + B + `in_cin`.

## Test plan
- Add with full carry ripple:
  - Stimulus: NIBBLES=4, A=0xFFFF, B=0x0001, `in_cin`=0, `out_ready`=1.
  - Response: `add_cin` sequence is 0,1,1,1. `out_sum`=0x0000 and `out_cout`=1, with `out_valid` 5 cycles after the accept edge.
- Add without carry:
  - Stimulus: A=0x1234, B=0x4321, `in_cin`=1.
  - Response: `out_sum`=0x5556, `out_cout`=0.
  - Stimulus: `in_valid` held high during RUN with different operands.
  - Response: those operands are ignored.
- Backpressure:
  - Stimulus: `out_ready`=0 for 6 cycles after `out_valid`.
  - Response: `out_valid`, `out_sum` and `out_cout` stable, and `in_ready`=0 throughout. Then `out_ready`=1 for one cycle gives `in_ready`=1 on the next cycle.
- Reset mid-run:
  - Stimulus: `rst_n` pulled low after the 2nd RUN edge.
  - Response: outputs go to 0 and `in_ready`=1 asynchronously. No `out_valid` follows. A new request A=0x0001, B=0x0001 gives `out_sum`=0x0002.
- Subtract, with `NIBBLE_ADD_SEQ_SUB_EN` defined:
  - Stimulus: A=0x0005, B=0x0007, `in_sub`=1.
  - Response: `out_sum`=0xFFFE, `out_cout`=0.
  - Stimulus: A=0x0007, B=0x0005, `in_sub`=1.
  - Response: `out_sum`=0x0002, `out_cout`=1.
  - Without the macro, A=0x0007, B=0x0005, `in_sub`=1, `in_cin`=0 gives 0x000C.

Source files
------------

// File: rtl/nibble_add_seq.sv
// Sequential feeder/collector around an external 4-bit ripple adder.
// Optional subtract support: define NIBBLE_ADD_SEQ_SUB_EN.
`timescale 1ns/1ps
module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_a,
  input  logic [4*NIBBLES-1:0] in_b,
  input  logic                 in_cin,
  input  logic                 in_sub,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_sum,
  input  logic                 add_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_sum,
  output logic                 out_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_carry;
  logic [IW-1:0]   r_idx;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic [W-1:0]    w_b_in;
  logic            w_cin_in;
  logic            w_run;

`ifdef NIBBLE_ADD_SEQ_SUB_EN
  // A - B as A + ~B + 1; carry-out high means no borrow
  assign w_b_in   = in_sub ? ~in_b : in_b;
  assign w_cin_in = in_sub | in_cin;
`else
  logic w_unused_sub;
  assign w_unused_sub = in_sub;
  assign w_b_in       = in_b;
  assign w_cin_in     = in_cin;
`endif

  assign w_run     = (r_state == S_RUN);
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
  assign add_a     = w_run ? r_a[{r_idx, 2'b00} +: 4] : 4'h0;
  assign add_b     = w_run ? r_b[{r_idx, 2'b00} +: 4] : 4'h0;
  assign add_cin   = w_run & r_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= w_b_in;
            r_carry <= w_cin_in;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum[{r_idx, 2'b00} +: 4] <= add_sum;
          r_carry <= add_cout;
          if (r_idx == LAST) begin
            r_cout  <= add_cout;
            r_idx   <= '0;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed bench for nibble_add_seq (NIBBLES=4) with a behavioural 4-bit adder.
`timescale 1ns/1ps
module tb_nibble_add_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_cin = 1'b0;
  logic        in_sub = 1'b0;
  logic [3:0]  add_a;
  logic [3:0]  add_b;
  logic        add_cin;
  logic [3:0]  add_sum;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_sum;
  logic        out_cout;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);
  end

  nibble_add_seq #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout)
  );

  // Drive one request, wait (bounded) for out_valid, hand it off.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub,
                       output logic [15:0] s, output logic c,
                       output int lat);
    @(negedge clk);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    s = out_sum;
    c = out_cout;
    if (lat > 0) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #2;
    n_vec++;
    if ({in_ready, out_valid, out_cout, add_cin} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_ctl got %b want 1000",
               {in_ready, out_valid, out_cout, add_cin});
    end
    n_vec++;
    if ({out_sum, add_a, add_b} !== 24'h0) begin
      n_err++;
      $display("FAIL reset_data got %h want 0", {out_sum, add_a, add_b});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_carry_ripple;
    logic [3:0] exp_cin;
    logic [3:0] exp_b;
    exp_cin = 4'b1110;
    exp_b   = 4'b0001;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ripple_ready got %b want 1", in_ready);
    end
    in_a = 16'hFFFF; in_b = 16'h0001; in_cin = 1'b0; in_sub = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      n_vec++;
      if ({add_a, add_b[0], add_cin} !== {4'hF, exp_b[i], exp_cin[i]}) begin
        n_err++;
        $display("FAIL ripple_nib%0d got a=%h b0=%b cin=%b want a=f b0=%b cin=%b",
                 i, add_a, add_b[0], add_cin, exp_b[i], exp_cin[i]);
      end
    end
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ripple_early_valid got %b want 0", out_valid);
    end
    @(negedge clk);
    n_vec++;
    if ({out_valid, out_sum, out_cout} !== {1'b1, 16'h0000, 1'b1}) begin
      n_err++;
      $display("FAIL ripple_result got v=%b s=%h c=%b want v=1 s=0000 c=1",
               out_valid, out_sum, out_cout);
    end
    @(negedge clk);
    n_vec++;
    if ({in_ready, out_valid, add_a, add_cin} !== {1'b1, 1'b0, 4'h0, 1'b0}) begin
      n_err++;
      $display("FAIL ripple_idle got r=%b v=%b a=%h ci=%b want r=1 v=0 a=0 ci=0",
               in_ready, out_valid, add_a, add_cin);
    end
  endtask

  task automatic test_ignore_in_run;
    @(negedge clk);
    in_a = 16'h1234; in_b = 16'h4321; in_cin = 1'b1; in_sub = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_a = 16'hAAAA; in_b = 16'h5555; in_cin = 1'b0;
      if (i == 1) begin
        n_vec++;
        if (in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL ignore_ready got %b want 0", in_ready);
        end
      end
    end
    in_valid = 1'b0;
    n_vec++;
    if ({out_valid, out_sum, out_cout} !== {1'b1, 16'h5556, 1'b0}) begin
      n_err++;
      $display("FAIL ignore_result got v=%b s=%h c=%b want v=1 s=5556 c=0",
               out_valid, out_sum, out_cout);
    end
    @(negedge clk);
    n_vec++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL ignore_no_reaccept got %b want 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    in_a = 16'h8000; in_b = 16'h8001; in_cin = 1'b0; in_sub = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if ({out_valid, in_ready, out_sum, out_cout} !==
          {1'b1, 1'b0, 16'h0001, 1'b1}) begin
        n_err++;
        $display("FAIL bp_hold%0d got v=%b r=%b s=%h c=%b want v=1 r=0 s=0001 c=1",
                 i, out_valid, in_ready, out_sum, out_cout);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL bp_release got %b want 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_reset_mid_run;
    logic [15:0] s;
    logic        c;
    int          lat;
    logic        seen;
    @(negedge clk);
    in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b0; in_sub = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({in_ready, out_valid, out_cout, add_cin} !== 4'b1000) begin
      n_err++;
      $display("FAIL midrst_ctl got %b want 1000",
               {in_ready, out_valid, out_cout, add_cin});
    end
    n_vec++;
    if ({out_sum, add_a, add_b} !== 24'h0) begin
      n_err++;
      $display("FAIL midrst_data got %h want 0", {out_sum, add_a, add_b});
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_no_valid got %b want 0", seen);
    end
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, s, c, lat);
    n_vec++;
    if ({s, c, lat} !== {16'h0002, 1'b0, 32'd5}) begin
      n_err++;
      $display("FAIL midrst_after got s=%h c=%b lat=%0d want s=0002 c=0 lat=5",
               s, c, lat);
    end
  endtask

  task automatic test_sub;
    logic [15:0] s;
    logic        c;
    int          lat;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, s, c, lat);
    n_vec++;
    if ({s, c, lat} !== {16'hFFFE, 1'b0, 32'd5}) begin
      n_err++;
      $display("FAIL sub_borrow got s=%h c=%b lat=%0d want s=fffe c=0 lat=5",
               s, c, lat);
    end
    do_op(16'h0007, 16'h0005, 1'b0, 1'b1, s, c, lat);
    n_vec++;
    if ({s, c, lat} !== {16'h0002, 1'b1, 32'd5}) begin
      n_err++;
      $display("FAIL sub_noborrow got s=%h c=%b lat=%0d want s=0002 c=1 lat=5",
               s, c, lat);
    end
`else
    do_op(16'h0007, 16'h0005, 1'b0, 1'b1, s, c, lat);
    n_vec++;
    if ({s, c, lat} !== {16'h000C, 1'b0, 32'd5}) begin
      n_err++;
      $display("FAIL sub_disabled got s=%h c=%b lat=%0d want s=000c c=0 lat=5",
               s, c, lat);
    end
`endif
    do_op(16'hABCD, 16'h6543, 1'b1, 1'b0, s, c, lat);
    n_vec++;
    if ({s, c, lat} !== {16'h1111, 1'b1, 32'd5}) begin
      n_err++;
      $display("FAIL add_mixed got s=%h c=%b lat=%0d want s=1111 c=1 lat=5",
               s, c, lat);
    end
  endtask

  initial begin
    test_reset;
    test_carry_ripple;
    test_ignore_in_run;
    test_backpressure;
    test_reset_mid_run;
    test_sub;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
